jk_reg_arbiter: RTL and testbench

JK_REG_ARBITER -- requirements
Module: jk_reg_arbiter

---
 rtl/jk_pkg.sv | 27 ++
 rtl/jk_reg_bank.sv | 29 ++
 rtl/jk_reg_arbiter.sv | 102 ++++++++++
 tb/tb_jk_reg_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK register arbiter: FSM encoding and the
// per-bit J/K command decode.
package jk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // {J,K} command encodings
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        case ({j, k})
            JK_HOLD:  r = q;
            JK_CLEAR: r = 1'b0;
            JK_SET:   r = 1'b1;
            default:  r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with a common enable and synchronous
// active-low reset.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             n_rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    always_ff @(posedge CP) begin
        if (!n_rst) begin
            Q <= '0;
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                Q[i] <= jk_next(Q[i], j[i], k[i]);
            end
        end
    end

    assign Qbar = ~Q;

endmodule

// File: rtl/jk_reg_arbiter.sv
// Two-requester round-robin arbiter that applies a captured J/K command to a
// shared register bank cnt+1 times, then pulses done to the owner.
module jk_reg_arbiter
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             CP,
    input  logic             n_rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_j,
    input  logic [WIDTH-1:0] req0_k,
    input  logic [WIDTH-1:0] req1_j,
    input  logic [WIDTH-1:0] req1_k,
    input  logic [CNTW-1:0]  req0_cnt,
    input  logic [CNTW-1:0]  req1_cnt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             busy,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output state_t           fsm_state
);

    state_t           state, state_next;
    logic             ptr;
    logic [CNTW-1:0]  rem;
    logic [WIDTH-1:0] cap_j, cap_k;
    logic [1:0]       ready, accept;

    // Handshake: a command transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; ready is offered only in IDLE, one-hot.
    always_comb begin
        ready      = '0;
        state_next = state;
        if (n_rst && state == IDLE) begin
            if (req_valid == 2'b11) ready = ptr ? 2'b10 : 2'b01;
            else                    ready = req_valid;
        end
        accept = req_valid & ready;
        case (state)
            IDLE:    if (|accept) state_next = BUSY;
            BUSY:    if (rem == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CP) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge CP) begin
        if (!n_rst) begin
            grant <= '0;
            done  <= '0;
            rem   <= '0;
            ptr   <= 1'b0;
            cap_j <= '0;
            cap_k <= '0;
        end else begin
            done <= '0;
            if (state == IDLE && |accept) begin
                grant <= accept;
                ptr   <= accept[0];
                if (accept[1]) begin
                    cap_j <= req1_j;
                    cap_k <= req1_k;
                    rem   <= req1_cnt;
                end else begin
                    cap_j <= req0_j;
                    cap_k <= req0_k;
                    rem   <= req0_cnt;
                end
            end else if (state == BUSY) begin
                if (rem == '0) begin
                    done  <= grant;
                    grant <= '0;
                end else begin
                    rem <= rem - CNTW'(1);
                end
            end
        end
    end

    jk_reg_bank #(.WIDTH(WIDTH)) u_bank (
        .CP    (CP),
        .n_rst (n_rst),
        .en    (state == BUSY),
        .j     (cap_j),
        .k     (cap_k),
        .Q     (Q),
        .Qbar  (Qbar)
    );

    assign req_ready = ready;
    assign busy      = (state == BUSY);
    assign fsm_state = state;

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// Directed bench for jk_reg_arbiter: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_jk_reg_arbiter;
    import jk_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic             CP = 1'b0;
    logic             n_rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_j, req0_k, req1_j, req1_k;
    logic [CNTW-1:0]  req0_cnt, req1_cnt;
    logic [WIDTH-1:0] Q, Qbar;
    logic             busy;
    logic [1:0]       grant, done;
    state_t           fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // clock / reset
    always #5 CP = ~CP;

    jk_reg_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .CP        (CP),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_j    (req0_j),
        .req0_k    (req0_k),
        .req1_j    (req1_j),
        .req1_k    (req1_k),
        .req0_cnt  (req0_cnt),
        .req1_cnt  (req1_cnt),
        .Q         (Q),
        .Qbar      (Qbar),
        .busy      (busy),
        .grant     (grant),
        .done      (done),
        .fsm_state (fsm_state)
    );

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_rst     = 1'b0;
        req_valid = 2'b11;
        req0_j = '0; req0_k = '0; req0_cnt = '0;
        req1_j = '0; req1_k = '0; req1_cnt = '0;
        tick();
        settle();
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        req_valid = 2'b00;
        n_rst     = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_q", 32'(Q), 32'h00);
        chk("rst_qbar", 32'(Qbar), 32'hFF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));

        // req0 set high nibble, single application
        req0_j = 8'hF0; req0_k = 8'h00; req0_cnt = 4'd0;
        req_valid = 2'b01;
        settle();
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_q_before", 32'(Q), 32'h00);
        chk("t1_ready_busy", 32'(req_ready), 32'h0);
        tick();
        chk("t1_q", 32'(Q), 32'hF0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_grant_clr", 32'(grant), 32'h0);
        tick();
        chk("t1_done_clr", 32'(done), 32'h0);

        // req1 toggle low nibble three times
        req1_j = 8'h0F; req1_k = 8'h0F; req1_cnt = 4'd2;
        req_valid = 2'b10;
        settle();
        chk("t2_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("t2_grant", 32'(grant), 32'h2);
        tick();
        chk("t2_q1", 32'(Q), 32'hFF);
        chk("t2_done1", 32'(done), 32'h0);
        tick();
        chk("t2_q2", 32'(Q), 32'hF0);
        chk("t2_busy2", 32'(busy), 32'h1);
        tick();
        chk("t2_q3", 32'(Q), 32'hFF);
        chk("t2_qbar3", 32'(Qbar), 32'h00);
        chk("t2_done3", 32'(done), 32'h2);
        chk("t2_idle", 32'(busy), 32'h0);
        tick();
        chk("t2_done_clr", 32'(done), 32'h0);

        // round robin after reset: 0,1,0,1
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        chk("t3_q_rst", 32'(Q), 32'h00);
        req0_j = 8'h01; req0_k = 8'h00; req0_cnt = 4'd0;
        req1_j = 8'h02; req1_k = 8'h00; req1_cnt = 4'd0;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] exp_g;
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            settle();
            chk("t3_ready", 32'(req_ready), 32'(exp_g));
            tick();
            chk("t3_grant", 32'(grant), 32'(exp_g));
            tick();
            chk("t3_done", 32'(done), 32'(exp_g));
        end
        req_valid = 2'b00;
        chk("t3_q", 32'(Q), 32'h03);

        // reset on third busy cycle of a long toggle command
        req0_j = 8'hFF; req0_k = 8'hFF; req0_cnt = 4'd7;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("t4_grant", 32'(grant), 32'h1);
        tick();
        chk("t4_q1", 32'(Q), 32'hFC);
        tick();
        chk("t4_q2", 32'(Q), 32'h03);
        n_rst = 1'b0;
        settle();
        chk("t4_ready_rst", 32'(req_ready), 32'h0);
        tick();
        chk("t4_q_rst", 32'(Q), 32'h00);
        chk("t4_busy_rst", 32'(busy), 32'h0);
        chk("t4_grant_rst", 32'(grant), 32'h0);
        chk("t4_done_rst", 32'(done), 32'h0);
        n_rst = 1'b1;
        tick();
        chk("t4_no_done", 32'(done), 32'h0);
        chk("t4_q_hold", 32'(Q), 32'h00);
        req0_j = 8'hAA; req0_k = 8'h00; req0_cnt = 4'd0;
        req_valid = 2'b01;
        settle();
        chk("t4_ready_after", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t4_grant_after", 32'(grant), 32'h1);
        tick();
        chk("t4_q_after", 32'(Q), 32'hAA);
        chk("t4_done_after", 32'(done), 32'h1);

        // inputs churn during busy; only captured req0 command applies
        req0_j = 8'h00; req0_k = 8'h0F; req0_cnt = 4'd1;
        req_valid = 2'b01;
        tick();
        chk("t5_grant", 32'(grant), 32'h1);
        for (int c = 0; c < 2; c++) begin
            req_valid = 2'b10;
            req0_j = 8'($urandom_range(0, 255)); req0_k = 8'($urandom_range(0, 255));
            req1_j = 8'($urandom_range(0, 255)); req1_k = 8'($urandom_range(0, 255));
            req0_cnt = 4'($urandom_range(0, 15)); req1_cnt = 4'($urandom_range(0, 15));
            settle();
            chk("t5_ready_busy", 32'(req_ready), 32'h0);
            tick();
            chk("t5_q", 32'(Q), 32'hA0);
        end
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_grant_clr", 32'(grant), 32'h0);
        // req1 withdraws before it can be accepted
        req_valid = 2'b00;
        tick();
        chk("t5_withdraw_busy", 32'(busy), 32'h0);
        chk("t5_withdraw_grant", 32'(grant), 32'h0);
        chk("t5_withdraw_q", 32'(Q), 32'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
